// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: shared state encoding, default timing and address helpers
// for the DRAM command controller. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

package dram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_ACT     = 3'd2,
        ST_ACCESS  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_REF     = 3'd5
    } state_t;

    localparam int DEF_T_RCD        = 2;
    localparam int DEF_T_RP         = 2;
    localparam int DEF_T_RFC        = 4;
    localparam int DEF_REF_INTERVAL = 64;

    // Row is the top ROW_W bits of the address.
    function automatic int unsigned row_of(input int unsigned addr,
                                           input int unsigned addr_w,
                                           input int unsigned row_w);
        return (addr >> (addr_w - row_w)) & ((32'd1 << row_w) - 32'd1);
    endfunction

    function automatic int unsigned width_of(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: free-running refresh interval counter with a sticky
// pending flag cleared by the controller when it enters refresh. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module dram_refresh_timer
    import dram_ctrl_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic pending
);

    localparam int CNT_W = width_of(REF_INTERVAL);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_INTERVAL - 1);

    logic [CNT_W-1:0] cnt;

    // A fresh expiry wins over a simultaneous clear so no interval is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= RELOAD;
            pending <= 1'b0;
        end else if (cnt == '0) begin
            cnt     <= RELOAD;
            pending <= 1'b1;
        end else begin
            cnt <= cnt - 1'b1;
            if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dram_cmd_ctrl.sv
// dram_cmd_ctrl: single-request open-page DRAM command sequencer with
// ACT/PRE timing and periodic refresh. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module dram_cmd_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int ROW_W        = 2,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RFC        = DEF_T_RFC,
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              refresh_active
);

    localparam int T_MAX = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                          : ((T_RP > T_RFC) ? T_RP : T_RFC);
    localparam int TMR_W = width_of(T_MAX);
    localparam logic [TMR_W-1:0] RCD_LD = TMR_W'(T_RCD - 1);
    localparam logic [TMR_W-1:0] RP_LD  = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] RFC_LD = TMR_W'(T_RFC - 1);

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic              row_open;
    logic [ROW_W-1:0]  open_row;
    logic              busy;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              refresh_pending;
    logic              accept;
    logic              timer_done;
    logic              enter_ref;
    logic [ROW_W-1:0]  req_row;
    logic [ROW_W-1:0]  lat_row;

    assign req_ready  = (state == ST_IDLE) && !refresh_pending;
    assign accept     = req_valid && req_ready;
    assign timer_done = (timer == '0);
    assign req_row    = ROW_W'(row_of(32'(req_addr), ADDR_W, ROW_W));
    assign lat_row    = ROW_W'(row_of(32'(addr_q), ADDR_W, ROW_W));

    // PRE only falls through to REF when no request is parked behind it.
    assign enter_ref = refresh_pending &&
                       (((state == ST_IDLE) && !row_open) ||
                        ((state == ST_PRE) && timer_done && !busy));

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    dram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_refresh (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (enter_ref),
        .pending (refresh_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            timer          <= '0;
            row_open       <= 1'b0;
            open_row       <= '0;
            busy           <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            mem_we         <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            refresh_active <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            rsp_valid <= 1'b0;
            if (!timer_done) begin
                timer <= timer - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (refresh_pending) begin
                        if (enter_ref) begin
                            state          <= ST_REF;
                            timer          <= RFC_LD;
                            refresh_active <= 1'b1;
                        end else begin
                            state <= ST_PRE;
                            timer <= RP_LD;
                        end
                    end else if (accept) begin
                        busy    <= 1'b1;
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (row_open && (req_row == open_row)) begin
                            state  <= ST_ACCESS;
                            mem_we <= req_we;
                        end else if (row_open) begin
                            state <= ST_PRE;
                            timer <= RP_LD;
                        end else begin
                            state <= ST_ACT;
                            timer <= RCD_LD;
                        end
                    end
                end

                ST_PRE: begin
                    row_open <= 1'b0;
                    if (timer_done) begin
                        if (enter_ref) begin
                            state          <= ST_REF;
                            timer          <= RFC_LD;
                            refresh_active <= 1'b1;
                        end else begin
                            state <= ST_ACT;
                            timer <= RCD_LD;
                        end
                    end
                end

                ST_ACT: begin
                    if (timer_done) begin
                        row_open <= 1'b1;
                        open_row <= lat_row;
                        state    <= ST_ACCESS;
                        mem_we   <= we_q;
                    end
                end

                ST_ACCESS: begin
                    if (we_q) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RD_WAIT;
                    end
                end

                // Array read data is registered, so it is valid in this cycle.
                ST_RD_WAIT: begin
                    rsp_rdata <= mem_rdata;
                    rsp_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                ST_REF: begin
                    row_open <= 1'b0;
                    if (timer_done) begin
                        refresh_active <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
